pc_sequencer: RTL and testbench

Fetch/execute control FSM that drives the CPU's program counter (load/increment strobes, next-address value) and the call/return stack pointer. It sits between the instruction decoder and the program counter. It resolves conditional branches from the C/Z flags, pushes and pops return addresses, and vectors interrupts.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/branch_cond.sv | 24 ++
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the program-counter sequencer.
// The PC_SEQ_INT_EN build option is handled in pc_sequencer.sv.
package pc_seq_pkg;

    localparam int PC_STATE_W = 2;

    typedef enum logic [PC_STATE_W-1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } pc_state_t;

    localparam logic [3:0] OP_SEQ   = 4'd0;
    localparam logic [3:0] OP_BRN   = 4'd1;
    localparam logic [3:0] OP_BREQ  = 4'd2;
    localparam logic [3:0] OP_BRNE  = 4'd3;
    localparam logic [3:0] OP_BRCS  = 4'd4;
    localparam logic [3:0] OP_BRCC  = 4'd5;
    localparam logic [3:0] OP_CALL  = 4'd6;
    localparam logic [3:0] OP_RET   = 4'd7;
    localparam logic [3:0] OP_RETID = 4'd8;
    localparam logic [3:0] OP_RETIE = 4'd9;
    localparam logic [3:0] OP_SEI   = 4'd10;
    localparam logic [3:0] OP_CLI   = 4'd11;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: decides whether a branch-class opcode is taken from C/Z.
// Non-branch opcodes always report not-taken.
module branch_cond
    import pc_seq_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       c_i,
    input  logic       z_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BRN:  taken_o = 1'b1;
            OP_BREQ: taken_o = z_i;
            OP_BRNE: taken_o = ~z_i;
            OP_BRCS: taken_o = c_i;
            OP_BRCC: taken_o = ~c_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute control FSM driving PC strobes, next-PC value and stack pointer.
// Define PC_SEQ_INT_EN to build in the interrupt path (INTR state, I_FLAG, flag shadowing).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INT_VECTOR = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] IMM_ADDR,
    input  logic             C_FLAG,
    input  logic             Z_FLAG,
    input  logic             INT,
    input  logic [WIDTH-1:0] PC_COUNT,
    input  logic [WIDTH-1:0] STK_DOUT,
    output logic             PC_RST,
    output logic             PC_LD,
    output logic             PC_INC,
    output logic [WIDTH-1:0] PC_DIN,
    output logic             IR_LD,
    output logic             STK_WE,
    output logic [WIDTH-1:0] STK_DIN,
    output logic             SP_DECR,
    output logic             SP_INCR,
    output logic             I_FLAG,
    output logic             FLG_SAVE,
    output logic             FLG_RESTORE,
    output pc_state_t        DBG_STATE
);

    pc_state_t state_q, state_d;
    logic      taken;

    branch_cond u_branch_cond (
        .op_i    (OP),
        .c_i     (C_FLAG),
        .z_i     (Z_FLAG),
        .taken_o (taken)
    );

`ifdef PC_SEQ_INT_EN
    logic i_flag_q, i_flag_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
        end
    end

    assign I_FLAG = i_flag_q;
`else
    logic unused_int;
    assign unused_int = INT;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign I_FLAG = 1'b0;
`endif

    assign DBG_STATE = state_q;

    always_comb begin
        state_d     = state_q;
        PC_RST      = 1'b0;
        PC_LD       = 1'b0;
        PC_INC      = 1'b0;
        PC_DIN      = '0;
        IR_LD       = 1'b0;
        STK_WE      = 1'b0;
        STK_DIN     = '0;
        SP_DECR     = 1'b0;
        SP_INCR     = 1'b0;
        FLG_SAVE    = 1'b0;
        FLG_RESTORE = 1'b0;
`ifdef PC_SEQ_INT_EN
        i_flag_d    = i_flag_q;
`endif
        // Strobes are gated by RST so a reset landing mid-push cannot leak a write.
        if (RST) begin
            case (state_q)
                ST_INIT: begin
                    PC_RST  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    IR_LD   = 1'b1;
                    PC_INC  = 1'b1;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (OP)
                        OP_BRN, OP_BREQ, OP_BRNE, OP_BRCS, OP_BRCC: begin
                            if (taken) begin
                                PC_LD  = 1'b1;
                                PC_DIN = IMM_ADDR;
                            end
                        end
                        OP_CALL: begin
                            STK_WE  = 1'b1;
                            STK_DIN = PC_COUNT;
                            SP_DECR = 1'b1;
                            PC_LD   = 1'b1;
                            PC_DIN  = IMM_ADDR;
                        end
                        OP_RET: begin
                            SP_INCR = 1'b1;
                            PC_LD   = 1'b1;
                            PC_DIN  = STK_DOUT;
                        end
`ifdef PC_SEQ_INT_EN
                        OP_RETID, OP_RETIE: begin
                            SP_INCR     = 1'b1;
                            PC_LD       = 1'b1;
                            PC_DIN      = STK_DOUT;
                            FLG_RESTORE = 1'b1;
                            i_flag_d    = (OP == OP_RETIE);
                        end
                        OP_SEI: i_flag_d = 1'b1;
                        OP_CLI: i_flag_d = 1'b0;
`else
                        OP_RETID, OP_RETIE: begin
                            SP_INCR = 1'b1;
                            PC_LD   = 1'b1;
                            PC_DIN  = STK_DOUT;
                        end
`endif
                        default: ;
                    endcase
`ifdef PC_SEQ_INT_EN
                    // Uses the pre-edge enable, so SEI/RETIE only arm the next instruction.
                    if (INT && i_flag_q) begin
                        state_d = ST_INTR;
                    end
`endif
                end
`ifdef PC_SEQ_INT_EN
                ST_INTR: begin
                    STK_WE   = 1'b1;
                    STK_DIN  = PC_COUNT;
                    SP_DECR  = 1'b1;
                    FLG_SAVE = 1'b1;
                    PC_LD    = 1'b1;
                    PC_DIN   = INT_VECTOR;
                    i_flag_d = 1'b0;
                    state_d  = ST_FETCH;
                end
`endif
                default: state_d = ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (works with or without PC_SEQ_INT_EN).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] op;
    logic [7:0] imm;
    logic       c_flag, z_flag, int_req;
    logic [7:0] pc_count, stk_dout;
    logic       pc_rst, pc_ld, pc_inc, ir_ld, stk_we, sp_decr, sp_incr;
    logic       i_flag, flg_save, flg_restore;
    logic [7:0] pc_din, stk_din;
    pc_state_t  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Strobe vector order: {PC_RST, PC_LD, PC_INC, IR_LD, STK_WE, SP_DECR, SP_INCR, FLG_SAVE, FLG_RESTORE}
    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_RST   = 9'b100000000;
    localparam logic [8:0] S_FETCH = 9'b001100000;
    localparam logic [8:0] S_LD    = 9'b010000000;
    localparam logic [8:0] S_CALL  = 9'b010011000;
    localparam logic [8:0] S_RET   = 9'b010000100;
    localparam logic [8:0] S_RETF  = 9'b010000101;
    localparam logic [8:0] S_INTR  = 9'b010011010;

    pc_sequencer dut (
        .CLK         (clk),
        .RST         (rst_n),
        .OP          (op),
        .IMM_ADDR    (imm),
        .C_FLAG      (c_flag),
        .Z_FLAG      (z_flag),
        .INT         (int_req),
        .PC_COUNT    (pc_count),
        .STK_DOUT    (stk_dout),
        .PC_RST      (pc_rst),
        .PC_LD       (pc_ld),
        .PC_INC      (pc_inc),
        .PC_DIN      (pc_din),
        .IR_LD       (ir_ld),
        .STK_WE      (stk_we),
        .STK_DIN     (stk_din),
        .SP_DECR     (sp_decr),
        .SP_INCR     (sp_incr),
        .I_FLAG      (i_flag),
        .FLG_SAVE    (flg_save),
        .FLG_RESTORE (flg_restore),
        .DBG_STATE   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] imm;
        logic       c;
        logic       z;
        logic       intr;
        logic [7:0] pc;
        logic [7:0] stk;
        logic [8:0] exp_strb;
        logic [7:0] exp_pc_din;
        logic [7:0] exp_stk_din;
        logic       exp_iflag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] im, input logic cc,
                                input logic zz, input logic ii, input logic [7:0] pc,
                                input logic [7:0] stk, input logic [8:0] es,
                                input logic [7:0] epd, input logic [7:0] esd, input logic ef);
        vec_t v;
        v.op = o; v.imm = im; v.c = cc; v.z = zz; v.intr = ii; v.pc = pc; v.stk = stk;
        v.exp_strb = es; v.exp_pc_din = epd; v.exp_stk_din = esd; v.exp_iflag = ef;
        return v;
    endfunction

    function automatic logic [8:0] strb();
        return {pc_rst, pc_ld, pc_inc, ir_ld, stk_we, sp_decr, sp_incr, flg_save, flg_restore};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " strobes"}, 16'(strb()), 16'(S_NONE));
        chk({name, " pc_din"}, 16'(pc_din), 16'h0);
        chk({name, " stk_din"}, 16'(stk_din), 16'h0);
        chk({name, " i_flag"}, 16'(i_flag), 16'h0);
        chk({name, " state"}, 16'(dbg_state), 16'(ST_INIT));
    endtask

    // Release reset on a falling edge; INIT must show PC_RST for that cycle.
    task automatic release_reset(input string name);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, " init strobes"}, 16'(strb()), 16'(S_RST));
        @(posedge clk);
    endtask

    task automatic fetch_cycle(input string name);
        @(negedge clk);
        #1;
        chk({name, " fetch strobes"}, 16'(strb()), 16'(S_FETCH));
        chk({name, " fetch state"}, 16'(dbg_state), 16'(ST_FETCH));
        @(posedge clk);
    endtask

    task automatic exec_cycle(input vec_t v, input string name);
        @(negedge clk);
        op = v.op; imm = v.imm; c_flag = v.c; z_flag = v.z;
        int_req = v.intr; pc_count = v.pc; stk_dout = v.stk;
        #1;
        chk({name, " strobes"}, 16'(strb()), 16'(v.exp_strb));
        chk({name, " pc_din"}, 16'(pc_din), 16'(v.exp_pc_din));
        chk({name, " stk_din"}, 16'(stk_din), 16'(v.exp_stk_din));
        @(posedge clk);
        #1;
        chk({name, " i_flag"}, 16'(i_flag), 16'(v.exp_iflag));
    endtask

`ifdef PC_SEQ_INT_EN
    task automatic intr_cycle(input logic [7:0] pc, input string name);
        @(negedge clk);
        pc_count = pc;
        #1;
        chk({name, " intr strobes"}, 16'(strb()), 16'(S_INTR));
        chk({name, " intr pc_din"}, 16'(pc_din), 16'h00ff);
        chk({name, " intr stk_din"}, 16'(stk_din), 16'(pc));
        chk({name, " intr state"}, 16'(dbg_state), 16'(ST_INTR));
        @(posedge clk);
        #1;
        chk({name, " intr i_flag"}, 16'(i_flag), 16'h0);
    endtask
`endif

    initial begin
        rst_n = 1'b0; op = OP_SEQ; imm = 8'h00; c_flag = 1'b0; z_flag = 1'b0;
        int_req = 1'b0; pc_count = 8'h00; stk_dout = 8'h00;

        //           op        imm    c  z  int pc     stk    strobes exp_pc  exp_stk iflag
        vecs.push_back(mk(OP_SEQ,  8'h12, 0, 0, 0, 8'h01, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_BRN,  8'h33, 0, 0, 0, 8'h02, 8'h00, S_LD,   8'h33, 8'h00, 0));
        vecs.push_back(mk(OP_BREQ, 8'h40, 0, 1, 0, 8'h03, 8'h00, S_LD,   8'h40, 8'h00, 0));
        vecs.push_back(mk(OP_BREQ, 8'h40, 1, 0, 0, 8'h04, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_BRNE, 8'h55, 1, 0, 0, 8'h05, 8'h00, S_LD,   8'h55, 8'h00, 0));
        vecs.push_back(mk(OP_BRNE, 8'h55, 0, 1, 0, 8'h06, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_BRCS, 8'h66, 1, 0, 0, 8'h07, 8'h00, S_LD,   8'h66, 8'h00, 0));
        vecs.push_back(mk(OP_BRCS, 8'h66, 0, 1, 0, 8'h08, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_BRCC, 8'h77, 0, 1, 0, 8'h09, 8'h00, S_LD,   8'h77, 8'h00, 0));
        vecs.push_back(mk(OP_BRCC, 8'h77, 1, 0, 0, 8'h0a, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_CALL, 8'h80, 0, 0, 0, 8'h11, 8'h5a, S_CALL, 8'h80, 8'h11, 0));
        vecs.push_back(mk(OP_RET,  8'h80, 0, 0, 0, 8'h81, 8'h11, S_RET,  8'h11, 8'h00, 0));
        vecs.push_back(mk(4'd13,   8'h99, 1, 1, 0, 8'h12, 8'h34, S_NONE, 8'h00, 8'h00, 0));
`ifdef PC_SEQ_INT_EN
        vecs.push_back(mk(OP_SEI,  8'h00, 0, 0, 0, 8'h13, 8'h00, S_NONE, 8'h00, 8'h00, 1));
        vecs.push_back(mk(OP_CLI,  8'h00, 0, 0, 0, 8'h14, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_RETIE,8'h00, 0, 0, 0, 8'h15, 8'h22, S_RETF, 8'h22, 8'h00, 1));
        vecs.push_back(mk(OP_RETID,8'h00, 0, 0, 0, 8'h23, 8'h2a, S_RETF, 8'h2a, 8'h00, 0));
`else
        vecs.push_back(mk(OP_SEI,  8'h00, 0, 0, 1, 8'h13, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_SEQ,  8'h00, 0, 0, 1, 8'h14, 8'h00, S_NONE, 8'h00, 8'h00, 0));
        vecs.push_back(mk(OP_RETIE,8'h00, 0, 0, 1, 8'h15, 8'h22, S_RET,  8'h22, 8'h00, 0));
        vecs.push_back(mk(OP_RETID,8'h00, 0, 0, 0, 8'h23, 8'h2a, S_RET,  8'h2a, 8'h00, 0));
        vecs.push_back(mk(OP_CLI,  8'h00, 0, 0, 0, 8'h2b, 8'h00, S_NONE, 8'h00, 8'h00, 0));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_idle("reset");
        release_reset("boot");

        for (int i = 0; i < vecs.size(); i++) begin
            fetch_cycle($sformatf("vec%0d", i));
            exec_cycle(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef PC_SEQ_INT_EN
        // SEI with INT already high: interrupt lands after the following instruction.
        fetch_cycle("sei_pend");
        exec_cycle(mk(OP_SEI, 8'h00, 0, 0, 1, 8'h20, 8'h00, S_NONE, 8'h00, 8'h00, 1), "sei_pend sei");
        fetch_cycle("sei_pend next");
        exec_cycle(mk(OP_SEQ, 8'h00, 0, 0, 1, 8'h21, 8'h00, S_NONE, 8'h00, 8'h00, 1), "sei_pend seq");
        intr_cycle(8'h21, "sei_pend");
        fetch_cycle("sei_pend after");
        exec_cycle(mk(OP_SEQ, 8'h00, 0, 0, 1, 8'h02, 8'h00, S_NONE, 8'h00, 8'h00, 0), "masked seq");

        // RETIE with INT high: no INTR right away, taken after the next instruction.
        fetch_cycle("retie_pend");
        exec_cycle(mk(OP_RETIE, 8'h00, 0, 0, 1, 8'h03, 8'h24, S_RETF, 8'h24, 8'h00, 1), "retie_pend retie");
        fetch_cycle("retie_pend next");
        exec_cycle(mk(OP_SEQ, 8'h00, 0, 0, 1, 8'h30, 8'h00, S_NONE, 8'h00, 8'h00, 1), "retie_pend seq");
        intr_cycle(8'h30, "retie_pend");

        // CALL with INT pending: call completes, INTR pushes the call target.
        fetch_cycle("call_pend sei");
        exec_cycle(mk(OP_SEI, 8'h00, 0, 0, 0, 8'h31, 8'h00, S_NONE, 8'h00, 8'h00, 1), "call_pend sei");
        fetch_cycle("call_pend");
        exec_cycle(mk(OP_CALL, 8'h90, 0, 0, 1, 8'h41, 8'h00, S_CALL, 8'h90, 8'h41, 1), "call_pend call");
        intr_cycle(8'h90, "call_pend");

        // Reset asserted during INTR: strobes drop and state returns to INIT immediately.
        fetch_cycle("rst_intr sei");
        exec_cycle(mk(OP_SEI, 8'h00, 0, 0, 0, 8'h91, 8'h00, S_NONE, 8'h00, 8'h00, 1), "rst_intr sei");
        fetch_cycle("rst_intr");
        exec_cycle(mk(OP_SEQ, 8'h00, 0, 0, 1, 8'h50, 8'h00, S_NONE, 8'h00, 8'h00, 1), "rst_intr seq");
        @(negedge clk);
        pc_count = 8'h50;
        #1;
        chk("rst_intr pre strobes", 16'(strb()), 16'(S_INTR));
        chk("rst_intr pre state", 16'(dbg_state), 16'(ST_INTR));
        rst_n = 1'b0;
        #1;
        chk_idle("rst_intr");
        int_req = 1'b0;
        repeat (2) @(posedge clk);
        release_reset("rst_intr");
        fetch_cycle("rst_intr after");
`else
        fetch_cycle("pre_rst_call");
`endif

        // Reset asserted during a CALL exec: no push strobe survives the async edge.
        @(negedge clk);
        op = OP_CALL; imm = 8'ha0; pc_count = 8'h61; int_req = 1'b0;
        #1;
        chk("rst_call pre strobes", 16'(strb()), 16'(S_CALL));
        rst_n = 1'b0;
        #1;
        chk_idle("rst_call");
        repeat (2) @(posedge clk);
        release_reset("rst_call");
        fetch_cycle("rst_call after");
        exec_cycle(mk(OP_BRN, 8'hc3, 0, 0, 0, 8'h01, 8'h00, S_LD, 8'hc3, 8'h00, 0), "rst_call brn");
        fetch_cycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
